// File: rtl/nivel2_timer.sv
// Microwave countdown timer: BCD MM:SS keypad entry, countdown while the magnetron is on.
// Define TIMER_PRESCALER_EN to derive the one-second tick from clk (CLK_DIV cycles) instead of tick_in.
module nivel2_timer #(
    parameter int CLK_DIV = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mag_on,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       tick_in,
    output logic       timer_done,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
    logic [3:0] w_min_tens_next, w_min_ones_next, w_sec_tens_next, w_sec_ones_next;
    logic [3:0] w_dec_min_tens, w_dec_min_ones, w_dec_sec_tens, w_dec_sec_ones;
    logic       r_done;
    logic       w_zero;
    logic       w_dec_zero;
    logic       w_key_ok;
    logic       w_tick;

    assign w_zero     = (r_min_tens == 4'd0) && (r_min_ones == 4'd0) &&
                        (r_sec_tens == 4'd0) && (r_sec_ones == 4'd0);
    assign w_dec_zero = (w_dec_min_tens == 4'd0) && (w_dec_min_ones == 4'd0) &&
                        (w_dec_sec_tens == 4'd0) && (w_dec_sec_ones == 4'd0);
    assign w_key_ok   = key_valid && (key_digit <= 4'd9);

`ifdef TIMER_PRESCALER_EN
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    logic [PW-1:0] r_prescale;
    logic          w_unused_tick;

    assign w_unused_tick = tick_in;
    assign w_tick        = (r_state == RUN) && (r_prescale == PW'(CLK_DIV - 1));

    // Counts only while staying in RUN, so every RUN entry starts a full CLK_DIV period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
        end else if (!clearn || r_state != RUN || w_state_next != RUN || w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end
`else
    logic [31:0] w_unused_div;

    assign w_unused_div = CLK_DIV;
    assign w_tick       = (r_state == RUN) && tick_in;
`endif

    // One-second BCD decrement; seconds tens wrap to 5, other digits to 9.
    always_comb begin
        w_dec_min_tens = r_min_tens;
        w_dec_min_ones = r_min_ones;
        w_dec_sec_tens = r_sec_tens;
        w_dec_sec_ones = r_sec_ones - 4'd1;
        if (r_sec_ones == 4'd0) begin
            w_dec_sec_ones = 4'd9;
            if (r_sec_tens == 4'd0) begin
                w_dec_sec_tens = 4'd5;
                if (r_min_ones == 4'd0) begin
                    w_dec_min_ones = 4'd9;
                    w_dec_min_tens = r_min_tens - 4'd1;
                end else begin
                    w_dec_min_ones = r_min_ones - 4'd1;
                end
            end else begin
                w_dec_sec_tens = r_sec_tens - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_min_tens_next = r_min_tens;
        w_min_ones_next = r_min_ones;
        w_sec_tens_next = r_sec_tens;
        w_sec_ones_next = r_sec_ones;
        if (r_state != RUN && w_key_ok) begin
            w_min_tens_next = r_min_ones;
            w_min_ones_next = r_sec_tens;
            w_sec_tens_next = r_sec_ones;
            w_sec_ones_next = key_digit;
            w_state_next    = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mag_on) begin
                        w_state_next = w_zero ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_tick && !w_zero) begin
                        w_min_tens_next = w_dec_min_tens;
                        w_min_ones_next = w_dec_min_ones;
                        w_sec_tens_next = w_dec_sec_tens;
                        w_sec_ones_next = w_dec_sec_ones;
                        if (w_dec_zero) begin
                            w_state_next = DONE;
                        end else if (!mag_on) begin
                            w_state_next = PAUSE;
                        end
                    end else if (!mag_on) begin
                        w_state_next = PAUSE;
                    end
                end
                PAUSE: begin
                    if (mag_on) begin
                        w_state_next = RUN;
                    end
                end
                default: begin
                    w_state_next = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_min_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
            r_done     <= 1'b0;
        end else if (!clearn) begin
            r_state    <= IDLE;
            r_min_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_min_tens <= w_min_tens_next;
            r_min_ones <= w_min_ones_next;
            r_sec_tens <= w_sec_tens_next;
            r_sec_ones <= w_sec_ones_next;
            r_done     <= (w_state_next == DONE);
        end
    end

    assign timer_done = r_done;
    assign min_tens   = r_min_tens;
    assign min_ones   = r_min_ones;
    assign sec_tens   = r_sec_tens;
    assign sec_ones   = r_sec_ones;
    assign running    = (r_state == RUN);

endmodule

// File: tb/tb_nivel2_timer.sv
// Scoreboard bench for nivel2_timer: expectations queued per driven cycle, compared after the edge.
// With TIMER_PRESCALER_EN defined it exercises the internal prescaler at CLK_DIV=4.
module tb_nivel2_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mag_on = 1'b0;
    logic       clearn = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       tick_in = 1'b0;
    logic       timer_done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;

    nivel2_timer #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mag_on     (mag_on),
        .clearn     (clearn),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .tick_in    (tick_in),
        .timer_done (timer_done),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] disp;
        logic        done;
        logic        run;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_disp = 16'h0000;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic push(input string tag, input logic [15:0] disp, input logic done, input logic run);
        exp_t e;
        e.tag  = tag;
        e.disp = disp;
        e.done = done;
        e.run  = run;
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t        e;
        logic [15:0] obs;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty observed=0 expected=1");
        end else begin
            e   = sb.pop_front();
            obs = {min_tens, min_ones, sec_tens, sec_ones};
            $display("txn %-12s disp=%h done=%b run=%b", e.tag, obs, timer_done, running);
            check({e.tag, ".disp"}, obs, e.disp);
            check({e.tag, ".done"}, 16'(timer_done), 16'(e.done));
            check({e.tag, ".run"}, 16'(running), 16'(e.run));
        end
    endtask

    task automatic cycle(input string tag, input logic [15:0] disp, input logic done, input logic run);
        push(tag, disp, done, run);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        m_disp    = {m_disp[11:0], d};
        cycle("key", m_disp, 1'b0, 1'b0);
        key_valid = 1'b0;
    endtask

    task automatic clear_all();
        clearn  = 1'b0;
        mag_on  = 1'b0;
        tick_in = 1'b0;
        m_disp  = 16'h0000;
        cycle("clear", 16'h0000, 1'b0, 1'b0);
        clearn  = 1'b1;
    endtask

    task automatic start();
        mag_on = 1'b1;
        cycle("start", m_disp, 1'b0, 1'b1);
    endtask

    task automatic countdown(input int from_s, input int n);
        int s;
        for (int i = 1; i <= n; i++) begin
            tick_in = 1'b1;
            s = from_s - i;
            cycle("tick", bcd(s), s == 0, s != 0);
        end
        tick_in = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        push("reset", 16'h0000, 1'b0, 1'b0);
        compare_head();
        @(negedge clk);
        reset = 1'b0;

        // Starting at 00:00 goes straight to DONE; done holds regardless of mag_on
        mag_on = 1'b1;
        cycle("zero_start", 16'h0000, 1'b1, 1'b0);
        mag_on = 1'b0;
        cycle("done_hold", 16'h0000, 1'b1, 1'b0);
        clear_all();

`ifndef TIMER_PRESCALER_EN
        // 01:30 counted fully down to 00:00
        press(4'd1); press(4'd3); press(4'd0);
        start();
        countdown(90, 90);
        mag_on = 1'b0;
        cycle("done_nomag", 16'h0000, 1'b1, 1'b0);
        clear_all();

        // Borrow chains
        press(4'd0); press(4'd1); press(4'd0); press(4'd0);
        start();
        countdown(60, 1);
        clear_all();
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        start();
        countdown(600, 1);
        clear_all();

        // Pause / resume, then a key in DONE
        press(4'd5);
        start();
        countdown(5, 2);
        mag_on = 1'b0;
        cycle("pause", 16'h0003, 1'b0, 1'b0);
        tick_in = 1'b1;
        repeat (3) cycle("pause_tick", 16'h0003, 1'b0, 1'b0);
        tick_in = 1'b0;
        mag_on = 1'b1;
        cycle("resume", 16'h0003, 1'b0, 1'b1);
        countdown(3, 3);
        mag_on = 1'b0;
        m_disp = 16'h0000;
        press(4'd7);
        clear_all();

        // Tick and mag_on falling together, then a key in PAUSE
        press(4'd3);
        start();
        tick_in = 1'b1;
        mag_on  = 1'b0;
        cycle("tick_pause", 16'h0002, 1'b0, 1'b0);
        tick_in = 1'b0;
        m_disp  = 16'h0002;
        press(4'd4);
        clear_all();
`else
        // Prescaler: tick_in ignored, decrements at cycles 4 and 8 after RUN entry
        tick_in = 1'b1;
        press(4'd2);
        start();
        for (int c = 1; c <= 8; c++) begin
            cycle("prescale", (c < 4) ? 16'h0002 : ((c < 8) ? 16'h0001 : 16'h0000),
                  c == 8, c != 8);
        end
        tick_in = 1'b0;
        clear_all();
`endif

        // Keys during RUN are ignored; clearn aborts the countdown
        press(4'd4); press(4'd0);
        start();
        key_valid = 1'b1;
        key_digit = 4'd7;
        cycle("key_in_run", 16'h0040, 1'b0, 1'b1);
        key_valid = 1'b0;
        clear_all();

        // Out-of-range digit ignored
        key_valid = 1'b1;
        key_digit = 4'd12;
        cycle("bad_key", m_disp, 1'b0, 1'b0);
        key_valid = 1'b0;

        // Asynchronous reset between edges mid-RUN
        press(4'd1); press(4'd5);
        start();
        cycle("run_hold", 16'h0015, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        push("async_reset", 16'h0000, 1'b0, 1'b0);
        compare_head();
        @(negedge clk);
        reset  = 1'b0;
        mag_on = 1'b0;
        m_disp = 16'h0000;
        cycle("post_reset", 16'h0000, 1'b0, 1'b0);
        cycle("post_reset", 16'h0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nivel2_timer.md
NIVEL2_TIMER -- requirements
Module: nivel2_timer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100, meaning clk cycles per one-second tick when the internal prescaler is compiled in.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port mag_on, input, 1 bit: magnetron-on level from the magnetron controller; enables the countdown.
REQ-005 The block SHALL have port clearn, input, 1 bit: active-low clear, synchronous.
REQ-006 The block SHALL have port key_valid, input, 1 bit: one-cycle strobe qualifying key_digit.
REQ-007 The block SHALL have port key_digit, input, 4 bits: BCD keypad digit.
REQ-008 The block SHALL have port tick_in, input, 1 bit: external one-second strobe, used only without the prescaler.
REQ-009 The block SHALL have port timer_done, output, 1 bit: registered level meaning the count reached 00:00; fed back to the magnetron controller.
REQ-010 The block SHALL have ports min_tens, min_ones, sec_tens, sec_ones, each output, 4 bits: registered BCD time display.
REQ-011 The block SHALL have port running, output, 1 bit: high while the FSM is in RUN.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN, PAUSE and DONE.
REQ-013 clearn low SHALL, on the next edge, clear all digits to 0, force the FSM to IDLE and drive timer_done low, with priority over every other input.
REQ-014 In IDLE, PAUSE or DONE, a key_valid with key_digit <= 9 SHALL shift the display left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
REQ-015 Key entry in DONE or PAUSE SHALL also move the FSM to IDLE and clear timer_done.
REQ-016 key_valid with key_digit > 9 SHALL be ignored, and key_valid SHALL be ignored in RUN.
REQ-017 In IDLE, mag_on high with a nonzero count SHALL move the FSM to RUN, and with a count of 00:00 SHALL move it to DONE on the next edge.
REQ-018 In RUN, mag_on low SHALL move the FSM to PAUSE with the digits held, and in PAUSE, mag_on high SHALL return the FSM to RUN.
REQ-019 In RUN, each one-second tick SHALL decrement the count by one second.
REQ-020 The decrement SHALL borrow as follows: sec_ones 0 becomes 9 with a borrow from sec_tens; sec_tens 0 becomes 5 with a borrow from min_ones; min_ones 0 becomes 9 with a borrow from min_tens.
REQ-021 Entered values such as sec_tens = 9 SHALL count down normally until the first borrow.
REQ-022 A tick that produces 00:00 SHALL, on that same edge, move the FSM to DONE and assert timer_done.
REQ-023 timer_done SHALL remain high in DONE until clearn or key entry, independent of mag_on.
REQ-024 A tick and mag_on falling in the same cycle SHALL both apply: decrement first, then PAUSE (or DONE if the count reaches zero).
REQ-025 running SHALL equal (state == RUN).
REQ-026 The decrement SHALL never be applied at 00:00, so the count cannot underflow.

Reset
REQ-027 reset high SHALL immediately and asynchronously force state IDLE, all digits 0, timer_done 0, running 0, and prescaler count 0.
REQ-028 Reset asserted mid-RUN SHALL abort the countdown, and after release the block SHALL behave as freshly powered, with no tick pending.

Configuration
REQ-029 With macro TIMER_PRESCALER_EN defined, a prescaler SHALL count clk cycles in RUN only, generate a tick every CLK_DIV cycles, and be held at 0 outside RUN.
REQ-030 With TIMER_PRESCALER_EN defined, the first decrement SHALL occur exactly CLK_DIV cycles after entering RUN, and tick_in SHALL be ignored.
REQ-031 With TIMER_PRESCALER_EN undefined, no prescaler SHALL be built, and tick_in high while in RUN SHALL be the one-second tick.

Verification
REQ-032 The bench SHALL cover: keys 1,3,0 then mag_on=1, 90 ticks -> display 01:30, 01:29, ..., 00:01, 00:00, with timer_done=1 on the 90th tick edge and running=0.
REQ-033 The bench SHALL cover: load 01:00, one tick -> 00:59 (borrow chain); load 10:00, one tick -> 09:59.
REQ-034 The bench SHALL cover: load 00:05, run 2 ticks, mag_on=0 -> PAUSE at 00:03 and further ticks ignored; mag_on=1, 3 ticks -> DONE.
REQ-035 The bench SHALL cover: in RUN at 00:40, clearn=0 for one cycle -> 00:00, IDLE, timer_done=0; keys pressed during RUN leave the display unchanged.
REQ-036 The bench SHALL cover: with TIMER_PRESCALER_EN and CLK_DIV=4, load 00:02, mag_on=1 -> decrements at cycles 4 and 8 after RUN entry, timer_done high at cycle 8.
REQ-037 The bench SHALL cover: reset pulsed asynchronously between clock edges mid-RUN -> outputs zero before the next edge; key_digit=12 with key_valid -> display unchanged.
